// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the two-requester SPI master arbiter.
package spi_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, GAP} arb_state_t;

    localparam int NUM_REQ = 2;
    localparam int CMD_W   = 16;

    // A lone pending slot wins; on contention the slot not served last wins.
    function automatic logic rr_pick(input logic [NUM_REQ-1:0] pend, input logic last_gnt);
        return (&pend) ? ~last_gnt : pend[1];
    endfunction

endpackage

// File: rtl/spi_req_slot.sv
// One requester's command slot: latches a command on an accepted strobe and
// flags a strobe that arrives while the previous command is still outstanding.
module spi_req_slot
    import spi_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wrt_i,
    input  logic [CMD_W-1:0] cmd_i,
    input  logic             grant_i,
    input  logic             release_i,
    output logic             pending_o,
    output logic             busy_o,
    output logic [CMD_W-1:0] cmd_q_o,
    output logic             err_o
);

    logic             pending_q, pending_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        pending_d = pending_q;
        busy_d    = busy_q;
        cmd_d     = cmd_q;
        err_d     = 1'b0;
        if (grant_i)   pending_d = 1'b0;
        if (release_i) busy_d    = 1'b0;
        if (wrt_i) begin
            if (busy_q) begin
                err_d = 1'b1;
            end else begin
                pending_d = 1'b1;
                busy_d    = 1'b1;
                cmd_d     = cmd_i;
            end
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            cmd_q     <= '0;
        end else begin
            pending_q <= pending_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            cmd_q     <= cmd_d;
        end
    end

    assign pending_o = pending_q;
    assign busy_o    = busy_q;
    assign cmd_q_o   = cmd_q;
    assign err_o     = err_q;

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI master between two requesters, with an
// enforced idle gap between transactions and a watchdog abort.
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int GAP_CYC = 4,
    parameter int TMO_CYC = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_wrt,
    input  logic [15:0] req0_cmd,
    input  logic        req1_wrt,
    input  logic [15:0] req1_cmd,
    output logic        req0_done,
    output logic        req1_done,
    output logic [15:0] req0_rd_data,
    output logic [15:0] req1_rd_data,
    output logic        req0_busy,
    output logic        req1_busy,
    output logic        req0_err,
    output logic        req1_err,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    input  logic        spi_done,
    input  logic [15:0] spi_rd_data
);

    localparam int GW = $clog2(GAP_CYC + 1);
    localparam int TW = $clog2(TMO_CYC + 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYC - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

    arb_state_t           state_q, state_d;
    logic                 gnt_q, gnt_d;
    logic                 last_gnt_q, last_gnt_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic [TW-1:0]        wdog_q, wdog_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [NUM_REQ-1:0]   tmo_err_q, tmo_err_d;
    logic [CMD_W-1:0]     rd_data_q [NUM_REQ];
    logic [CMD_W-1:0]     rd_data_d [NUM_REQ];

    logic [NUM_REQ-1:0]   slot_wrt, slot_grant, slot_release, slot_pending, slot_busy, slot_err;
    logic [CMD_W-1:0]     req_cmd  [NUM_REQ];
    logic [CMD_W-1:0]     slot_cmd [NUM_REQ];
    logic                 grant_fire, release_fire, pick;

    assign slot_wrt   = {req1_wrt, req0_wrt};
    assign req_cmd[0] = req0_cmd;
    assign req_cmd[1] = req1_cmd;
    assign pick       = rr_pick(slot_pending, last_gnt_q);

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
        assign slot_grant[i]   = grant_fire && (pick == 1'(i));
        assign slot_release[i] = release_fire && (gnt_q == 1'(i));

        spi_req_slot u_slot (
            .clk       (clk),
            .rst       (rst),
            .wrt_i     (slot_wrt[i]),
            .cmd_i     (req_cmd[i]),
            .grant_i   (slot_grant[i]),
            .release_i (slot_release[i]),
            .pending_o (slot_pending[i]),
            .busy_o    (slot_busy[i]),
            .cmd_q_o   (slot_cmd[i]),
            .err_o     (slot_err[i])
        );
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_gnt_d   = last_gnt_q;
        gap_d        = gap_q;
        wdog_d       = wdog_q;
        done_d       = '0;
        tmo_err_d    = '0;
        rd_data_d    = rd_data_q;
        grant_fire   = 1'b0;
        release_fire = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|slot_pending) begin
                    grant_fire = 1'b1;
                    gnt_d      = pick;
                    wdog_d     = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                // Completion wins over a watchdog expiry landing in the same cycle.
                if (spi_done) begin
                    release_fire     = 1'b1;
                    done_d[gnt_q]    = 1'b1;
                    rd_data_d[gnt_q] = spi_rd_data;
                    last_gnt_d       = gnt_q;
                    gap_d            = GAP_LOAD;
                    state_d          = GAP;
                end else if (wdog_q == TMO_LAST) begin
                    release_fire     = 1'b1;
                    tmo_err_d[gnt_q] = 1'b1;
                    last_gnt_d       = gnt_q;
                    gap_d            = GAP_LOAD;
                    state_d          = GAP;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_q == '0) state_d = IDLE;
                else             gap_d   = gap_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            gap_q      <= '0;
            wdog_q     <= '0;
            done_q     <= '0;
            tmo_err_q  <= '0;
            rd_data_q  <= '{default: '0};
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            gap_q      <= gap_d;
            wdog_q     <= wdog_d;
            done_q     <= done_d;
            tmo_err_q  <= tmo_err_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign spi_wrt      = grant_fire;
    assign spi_cmd      = grant_fire ? slot_cmd[pick] : '0;
    assign req0_done    = done_q[0];
    assign req1_done    = done_q[1];
    assign req0_rd_data = rd_data_q[0];
    assign req1_rd_data = rd_data_q[1];
    assign req0_busy    = slot_busy[0];
    assign req1_busy    = slot_busy[1];
    assign req0_err     = slot_err[0] | tmo_err_q[0];
    assign req1_err     = slot_err[1] | tmo_err_q[1];

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench for spi_bus_arbiter: vector table, directed corner
// sequences, then random traffic against a time-based reference model.
module tb_spi_bus_arbiter;

    localparam int GAP      = 4;
    localparam int TMO      = 16;
    localparam int RAND_CYC = 1500;
    localparam int NVEC     = 19;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_wrt, req1_wrt;
    logic [15:0] req0_cmd, req1_cmd;
    logic        req0_done, req1_done;
    logic [15:0] req0_rd_data, req1_rd_data;
    logic        req0_busy, req1_busy;
    logic        req0_err, req1_err;
    logic        spi_wrt;
    logic [15:0] spi_cmd;
    logic        spi_done;
    logic [15:0] spi_rd_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_n   = 0;

    spi_bus_arbiter #(.GAP_CYC(GAP), .TMO_CYC(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_wrt     (req0_wrt),
        .req0_cmd     (req0_cmd),
        .req1_wrt     (req1_wrt),
        .req1_cmd     (req1_cmd),
        .req0_done    (req0_done),
        .req1_done    (req1_done),
        .req0_rd_data (req0_rd_data),
        .req1_rd_data (req1_rd_data),
        .req0_busy    (req0_busy),
        .req1_busy    (req1_busy),
        .req0_err     (req0_err),
        .req1_err     (req1_err),
        .spi_wrt      (spi_wrt),
        .spi_cmd      (spi_cmd),
        .spi_done     (spi_done),
        .spi_rd_data  (spi_rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  w;      // {req1_wrt, req0_wrt}
        logic [15:0] c0;
        logic [15:0] c1;
        logic        sd;
        logic [15:0] sr;
        logic        e_wrt;
        logic [15:0] e_cmd;
        logic [1:0]  e_busy; // {port1, port0}
        logic [1:0]  e_done;
        logic [1:0]  e_err;
        logic [15:0] e_rd0;
        logic [15:0] e_rd1;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {9'd0, spi_wrt, spi_cmd, req1_busy, req0_busy, req1_done, req0_done,
                req1_err, req0_err, req0_rd_data, req1_rd_data};
    endfunction

    task automatic idle_inputs();
        req0_wrt = 1'b0; req1_wrt = 1'b0; spi_done = 1'b0;
        req0_cmd = 16'h0; req1_cmd = 16'h0; spi_rd_data = 16'h0;
    endtask

    // Cycle k spans posedge k .. posedge k+1; inputs and checks happen 2 time units in.
    task automatic adv_to(input int target);
        while (cyc_n < target) begin
            @(posedge clk);
            #2;
            cyc_n++;
            idle_inputs();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #2;
        rst   = 1'b0;
        cyc_n = 0;
    endtask

    // Reference model state for the random phase, expressed in cycle times.
    bit          m_pend [2];
    bit          m_busy [2];
    bit          m_done [2];
    bit          m_err  [2];
    logic [15:0] m_cmd  [2];
    logic [15:0] m_rd   [2];
    int          m_owner, m_gcyc, m_free, m_last;

    initial begin
        #2000000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        //             w      c0        c1        sd    sr        wrt   cmd       busy   done   err    rd0       rd1
        vecs[0]  = '{2'b01, 16'hA200, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000};
        vecs[1]  = '{2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'hA200, 2'b01, 2'b00, 2'b00, 16'h0000, 16'h0000};
        vecs[2]  = '{2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 2'b01, 2'b00, 2'b00, 16'h0000, 16'h0000};
        vecs[3]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 16'h00C5, 1'b0, 16'h0000, 2'b01, 2'b00, 2'b00, 16'h0000, 16'h0000};
        vecs[4]  = '{2'b11, 16'hA300, 16'h2000, 1'b0, 16'h0000, 1'b0, 16'h0000, 2'b00, 2'b01, 2'b00, 16'h00C5, 16'h0000};
        vecs[5]  = '{2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 2'b11, 2'b00, 2'b00, 16'h00C5, 16'h0000};
        vecs[6]  = '{2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 2'b11, 2'b00, 2'b00, 16'h00C5, 16'h0000};
        vecs[7]  = '{2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 2'b11, 2'b00, 2'b00, 16'h00C5, 16'h0000};
        vecs[8]  = '{2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h2000, 2'b11, 2'b00, 2'b00, 16'h00C5, 16'h0000};
        vecs[9]  = '{2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 2'b11, 2'b00, 2'b00, 16'h00C5, 16'h0000};
        vecs[10] = '{2'b00, 16'h0000, 16'h0000, 1'b1, 16'h1234, 1'b0, 16'h0000, 2'b11, 2'b00, 2'b00, 16'h00C5, 16'h0000};
        vecs[11] = '{2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 2'b01, 2'b10, 2'b00, 16'h00C5, 16'h1234};
        vecs[12] = '{2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 2'b01, 2'b00, 2'b00, 16'h00C5, 16'h1234};
        vecs[13] = '{2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 2'b01, 2'b00, 2'b00, 16'h00C5, 16'h1234};
        vecs[14] = '{2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 2'b01, 2'b00, 2'b00, 16'h00C5, 16'h1234};
        vecs[15] = '{2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'hA300, 2'b01, 2'b00, 2'b00, 16'h00C5, 16'h1234};
        vecs[16] = '{2'b01, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 2'b01, 2'b00, 2'b00, 16'h00C5, 16'h1234};
        vecs[17] = '{2'b00, 16'h0000, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 16'h0000, 2'b01, 2'b00, 2'b01, 16'h00C5, 16'h1234};
        vecs[18] = '{2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 2'b00, 2'b01, 2'b00, 16'hBEEF, 16'h1234};

        // Vector table: single transaction, contention after a done, reject in BUSY.
        do_reset();
        for (int i = 0; i < NVEC; i++) begin
            adv_to(i);
            req0_wrt = vecs[i].w[0]; req0_cmd = vecs[i].c0;
            req1_wrt = vecs[i].w[1]; req1_cmd = vecs[i].c1;
            spi_done = vecs[i].sd;   spi_rd_data = vecs[i].sr;
            check($sformatf("vec %0d", i), outs(),
                  {9'd0, vecs[i].e_wrt, vecs[i].e_cmd, vecs[i].e_busy, vecs[i].e_done,
                   vecs[i].e_err, vecs[i].e_rd0, vecs[i].e_rd1});
        end

        // Contention from reset; re-strobe on the done cycle; port 1 then wins.
        do_reset();
        req0_wrt = 1'b1; req0_cmd = 16'hA300; req1_wrt = 1'b1; req1_cmd = 16'h2000;
        adv_to(1);
        check("A first grant", {spi_wrt, spi_cmd}, {1'b1, 16'hA300});
        check("A both busy", {req1_busy, req0_busy}, 2'b11);
        adv_to(3); spi_done = 1'b1; spi_rd_data = 16'h0001;
        adv_to(4);
        check("A done0", {req0_done, req0_rd_data, req0_busy}, {1'b1, 16'h0001, 1'b0});
        req0_wrt = 1'b1; req0_cmd = 16'hA400;
        adv_to(5);
        check("A same-cycle accept", {req0_busy, req0_err}, 2'b10);
        adv_to(7);
        check("A gap no wrt", {spi_wrt, spi_cmd}, 17'd0);
        adv_to(8);
        check("A port1 after gap", {spi_wrt, spi_cmd}, {1'b1, 16'h2000});
        adv_to(10); spi_done = 1'b1; spi_rd_data = 16'h0002;
        adv_to(11);
        check("A done1", {req1_done, req0_done, req1_rd_data}, {2'b10, 16'h0002});
        adv_to(15);
        check("A port0 regrant", {spi_wrt, spi_cmd}, {1'b1, 16'hA400});
        adv_to(17); spi_done = 1'b1; spi_rd_data = 16'h0003;
        adv_to(18);
        check("A done0 again", {req0_done, req0_rd_data}, {1'b1, 16'h0003});

        // Rejected strobe while pending keeps the original command.
        do_reset();
        req0_wrt = 1'b1; req0_cmd = 16'h0AAA;
        adv_to(1); req1_wrt = 1'b1; req1_cmd = 16'h1111;
        adv_to(2);
        check("B accept1", {req1_busy, req1_err}, 2'b10);
        req1_wrt = 1'b1; req1_cmd = 16'h2222;
        adv_to(3);
        check("B reject err", {req1_err, req1_busy}, 2'b11);
        spi_done = 1'b1; spi_rd_data = 16'h0BBB;
        adv_to(4);
        check("B err one cycle", {req1_err, req0_done}, 2'b01);
        adv_to(8);
        check("B original cmd", {spi_wrt, spi_cmd}, {1'b1, 16'h1111});
        adv_to(10); spi_done = 1'b1; spi_rd_data = 16'h0CCC;
        adv_to(11);
        check("B done1", {req1_done, req1_rd_data}, {1'b1, 16'h0CCC});

        // Watchdog abort at grant+TMO+1, pending port 1 served after the gap.
        adv_to(15); req0_wrt = 1'b1; req0_cmd = 16'h5555;
        adv_to(16);
        check("C grant", {spi_wrt, spi_cmd}, {1'b1, 16'h5555});
        req1_wrt = 1'b1; req1_cmd = 16'h6666;
        for (int c = 17; c <= 32; c++) begin
            adv_to(c);
            check($sformatf("C quiet c%0d", c), {req0_err, req0_done, req0_busy}, 3'b001);
        end
        adv_to(33);
        check("C timeout err", {req0_err, req0_done, req0_busy, req0_rd_data}, {3'b100, 16'h0BBB});
        adv_to(34);
        check("C err one cycle", req0_err, 1'b0);
        spi_done = 1'b1; spi_rd_data = 16'hDEAD;
        adv_to(35);
        check("C done ignored in gap", {req1_done, req0_done, req0_rd_data, req1_rd_data},
              {2'b00, 16'h0BBB, 16'h0CCC});
        adv_to(36);
        check("C still gap", spi_wrt, 1'b0);
        adv_to(37);
        check("C port1 granted", {spi_wrt, spi_cmd}, {1'b1, 16'h6666});

        // Reset in BUSY drops the transaction silently.
        adv_to(38); rst = 1'b1;
        adv_to(39); rst = 1'b0;
        check("D reset outputs", outs(), 64'd0);
        adv_to(40); spi_done = 1'b1; spi_rd_data = 16'h7777;
        adv_to(41);
        check("D stray done", {req1_done, req0_done, req1_err, req0_err}, 4'b0000);
        adv_to(42);
        check("D idle after", outs(), 64'd0);

        // Random traffic against the reference model.
        do_reset();
        for (int p = 0; p < 2; p++) begin
            m_pend[p] = 0; m_busy[p] = 0; m_done[p] = 0; m_err[p] = 0;
            m_cmd[p] = 16'h0; m_rd[p] = 16'h0;
        end
        m_owner = -1; m_gcyc = 0; m_free = 0; m_last = 1;
        begin
            int          lat_cnt;
            int          pick, rel;
            bit          e_wrt;
            logic [15:0] e_cmd;
            bit          w [2];
            logic [15:0] cm [2];
            bit          n_done [2];
            bit          n_err  [2];
            lat_cnt = 0;
            for (int c = 0; c < RAND_CYC; c++) begin
                adv_to(c);
                w[0] = ($urandom_range(3) == 0); cm[0] = 16'($urandom);
                w[1] = ($urandom_range(3) == 0); cm[1] = 16'($urandom);
                req0_wrt = w[0]; req0_cmd = cm[0];
                req1_wrt = w[1]; req1_cmd = cm[1];
                if (lat_cnt > 0) begin
                    lat_cnt--;
                    spi_done = (lat_cnt == 0);
                end else begin
                    spi_done = ($urandom_range(31) == 0);
                end
                spi_rd_data = 16'($urandom);

                e_wrt = (m_owner < 0) && (c >= m_free) && (m_pend[0] || m_pend[1]);
                pick  = (m_pend[0] && m_pend[1]) ? 1 - m_last : (m_pend[0] ? 0 : 1);
                e_cmd = e_wrt ? m_cmd[pick] : 16'h0;
                check($sformatf("rand c%0d", c), outs(),
                      {9'd0, e_wrt, e_cmd, m_busy[1], m_busy[0], m_done[1], m_done[0],
                       m_err[1], m_err[0], m_rd[0], m_rd[1]});
                if (spi_wrt) lat_cnt = $urandom_range(20, 1);

                n_done[0] = 0; n_done[1] = 0; n_err[0] = 0; n_err[1] = 0; rel = -1;
                if (e_wrt) begin
                    m_owner = pick; m_pend[pick] = 0; m_gcyc = c;
                end else if (m_owner >= 0) begin
                    if (spi_done) begin
                        n_done[m_owner] = 1; m_rd[m_owner] = spi_rd_data; rel = m_owner;
                    end else if (c - m_gcyc == TMO) begin
                        n_err[m_owner] = 1; rel = m_owner;
                    end
                end
                for (int p = 0; p < 2; p++) begin
                    if (w[p]) begin
                        if (m_busy[p]) n_err[p] = 1;
                        else begin m_pend[p] = 1; m_busy[p] = 1; m_cmd[p] = cm[p]; end
                    end
                end
                if (rel >= 0) begin
                    m_busy[rel] = 0; m_last = rel; m_owner = -1; m_free = c + 1 + GAP;
                end
                m_done = n_done;
                m_err  = n_err;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
